// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: reset/NOP defaults, fetch FSM
// states and the word-increment constant.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_INC     = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus: req/addr held until ack, rdata valid with ack.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_buf.sv
// One-entry pc/word holding buffer; clear beats load, load beats drain.
module fetch_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_word,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_word
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_word  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_word  <= i_word;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_word  = r_word;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register with redirect/squash handling.
// Optional counters enabled by defining FETCH_STATS_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 pcjump,
  input  logic [31:0]          real_pc,
  input  logic                 ir_bubble,
  input  logic                 id_ready,
  output logic [31:0]          pc,
  output logic [31:0]          ir,
  output logic                 ir_valid,
  output logic [31:0]          fetch_cnt,
  output logic [31:0]          flush_cnt
);

  fetch_state_e r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_addr;
  logic         r_req;
  logic [31:0]  r_pc;
  logic [31:0]  r_ir;
  logic         r_ir_valid;

  logic         w_slot_free;
  logic         w_ack;
  logic         w_fetch_load;
  logic         w_buf_load;
  logic         w_buf_drain;
  logic         w_buf_valid;
  logic [31:0]  w_buf_pc;
  logic [31:0]  w_buf_word;
  logic [31:0]  w_pc_inc;

  assign w_pc_inc     = r_fetch_pc + WORD_INC;
  assign w_slot_free  = (!r_ir_valid || id_ready) && !ir_bubble;
  assign w_ack        = imem.imem_ack && r_req;
  assign w_fetch_load = !pcjump && (r_state == S_REQ) && w_ack && w_slot_free;
  assign w_buf_load   = !pcjump && (r_state == S_REQ) && w_ack && !w_slot_free;
  assign w_buf_drain  = !pcjump && (r_state == S_HOLD) && w_buf_valid && w_slot_free;

  fetch_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_clear (pcjump),
    .i_pc    (r_fetch_pc),
    .i_word  (imem.imem_rdata),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_word  (w_buf_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_pc       <= '0;
      r_ir       <= NOP_WORD;
      r_ir_valid <= 1'b0;
    end else if (pcjump) begin
      r_ir       <= NOP_WORD;
      r_ir_valid <= 1'b0;
      r_fetch_pc <= real_pc;
      r_req      <= 1'b1;
      // An outstanding read must still complete at its old address before retargeting.
      if (((r_state == S_REQ) || (r_state == S_FLUSH)) && !w_ack) begin
        r_state <= S_FLUSH;
      end else begin
        r_state <= S_REQ;
        r_addr  <= real_pc;
      end
    end else begin
      if (ir_bubble) begin
        r_ir       <= NOP_WORD;
        r_ir_valid <= 1'b0;
      end else if (w_fetch_load) begin
        r_ir       <= imem.imem_rdata;
        r_pc       <= r_fetch_pc;
        r_ir_valid <= 1'b1;
      end else if (w_buf_drain) begin
        r_ir       <= w_buf_word;
        r_pc       <= w_buf_pc;
        r_ir_valid <= 1'b1;
      end else if (id_ready) begin
        r_ir_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_addr  <= r_fetch_pc;
        end
        S_REQ: begin
          if (w_ack) begin
            r_fetch_pc <= w_pc_inc;
            r_addr     <= w_pc_inc;
            if (!w_slot_free) begin
              r_state <= S_HOLD;
              r_req   <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (w_buf_drain) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (w_ack) begin
            r_state <= S_REQ;
            r_addr  <= r_fetch_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign pc             = r_pc;
  assign ir             = r_ir;
  assign ir_valid       = r_ir_valid;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_fetch_load || w_buf_drain) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (pcjump) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// reset sequence, then randomized traffic against a delivered-sequence model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcjump;
  logic [31:0] real_pc;
  logic        ir_bubble;
  logic        id_ready;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

  int checks   = 0;
  int failures = 0;

  fetch_stage_if imem_if ();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // Memory responder: real data only on ack, garbage otherwise.
  assign imem_if.imem_rdata = imem_if.imem_ack ? mem_word(imem_if.imem_addr) : 32'hBAD0_BAD0;

  fetch_stage #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem      (imem_if),
    .pcjump    (pcjump),
    .real_pc   (real_pc),
    .ir_bubble (ir_bubble),
    .id_ready  (id_ready),
    .pc        (pc),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input int n_fetch, input int n_flush);
`ifdef FETCH_STATS_EN
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'(n_fetch));
    chk({tag, "_flush_cnt"}, flush_cnt, 32'(n_flush));
`else
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'(n_fetch) & 32'h0);
    chk({tag, "_flush_cnt"}, flush_cnt, 32'(n_flush) & 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pcjump = 1'b0; real_pc = '0; ir_bubble = 1'b0; id_ready = 1'b1;
    imem_if.imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_if.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, NOP);
    chk_counts("rst", 0, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        jump;
    logic [31:0] tgt;
    logic        bub;
    logic        rdy;
    logic        ack;
    logic        ld;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t v(input logic jump, input logic [31:0] tgt, input logic bub,
                             input logic rdy, input logic ack, input logic ld,
                             input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_pc);
    vec_t r;
    r.jump = jump; r.tgt = tgt; r.bub = bub; r.rdy = rdy; r.ack = ack; r.ld = ld;
    r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_pc = e_pc;
    return r;
  endfunction

  vec_t tbl[25];

  initial begin
    int n_ld;
    int n_jmp;
    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    logic        p_valid, p_rdy, p_bub, p_jump, p_req, p_ack;
    logic [31:0] p_tgt, p_addr;

    //         jump tgt           bub rdy ack ld  req addr           val pc
    tbl[0]  = v(0, 0,             0,  1,  0,  0,  1,  32'h0,         0,  0);
    tbl[1]  = v(0, 0,             0,  1,  1,  1,  1,  32'h4,         1,  32'h0);
    tbl[2]  = v(0, 0,             0,  1,  1,  1,  1,  32'h8,         1,  32'h4);
    tbl[3]  = v(0, 0,             0,  1,  1,  1,  1,  32'hC,         1,  32'h8);
    tbl[4]  = v(0, 0,             0,  0,  1,  0,  0,  0,             1,  32'h8);
    tbl[5]  = v(0, 0,             0,  0,  1,  0,  0,  0,             1,  32'h8);
    tbl[6]  = v(0, 0,             0,  0,  0,  0,  0,  0,             1,  32'h8);
    tbl[7]  = v(0, 0,             0,  1,  0,  1,  1,  32'h10,        1,  32'hC);
    tbl[8]  = v(0, 0,             0,  1,  1,  1,  1,  32'h14,        1,  32'h10);
    tbl[9]  = v(0, 0,             1,  1,  1,  0,  0,  0,             0,  0);
    tbl[10] = v(0, 0,             1,  1,  1,  0,  0,  0,             0,  0);
    tbl[11] = v(0, 0,             0,  1,  0,  1,  1,  32'h18,        1,  32'h14);
    tbl[12] = v(1, 32'h100,       0,  1,  0,  0,  1,  32'h18,        0,  0);
    tbl[13] = v(0, 0,             0,  1,  0,  0,  1,  32'h18,        0,  0);
    tbl[14] = v(0, 0,             0,  1,  1,  0,  1,  32'h100,       0,  0);
    tbl[15] = v(0, 0,             0,  1,  1,  1,  1,  32'h104,       1,  32'h100);
    tbl[16] = v(1, 32'h200,       0,  1,  1,  0,  1,  32'h200,       0,  0);
    tbl[17] = v(0, 0,             0,  1,  1,  1,  1,  32'h204,       1,  32'h200);
    tbl[18] = v(1, 32'hFFFF_FFFC, 0,  1,  1,  0,  1,  32'hFFFF_FFFC, 0,  0);
    tbl[19] = v(0, 0,             0,  1,  1,  1,  1,  32'h0,         1,  32'hFFFF_FFFC);
    tbl[20] = v(0, 0,             0,  1,  1,  1,  1,  32'h4,         1,  32'h0);
    tbl[21] = v(1, 32'h300,       0,  1,  0,  0,  1,  32'h4,         0,  0);
    tbl[22] = v(1, 32'h400,       0,  1,  0,  0,  1,  32'h4,         0,  0);
    tbl[23] = v(0, 0,             0,  1,  1,  0,  1,  32'h400,       0,  0);
    tbl[24] = v(0, 0,             0,  1,  1,  1,  1,  32'h404,       1,  32'h400);

    do_reset();
    n_ld = 0;
    n_jmp = 0;
    for (int i = 0; i < 25; i++) begin
      pcjump = tbl[i].jump; real_pc = tbl[i].tgt; ir_bubble = tbl[i].bub;
      id_ready = tbl[i].rdy; imem_if.imem_ack = tbl[i].ack;
      @(posedge clk);
      #1;
      n_ld  += int'(tbl[i].ld);
      n_jmp += int'(tbl[i].jump);
      $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h ir=%h", i,
               imem_if.imem_req, imem_if.imem_addr, ir_valid, pc, ir);
      chk($sformatf("vec%0d_req", i), {31'b0, imem_if.imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), imem_if.imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, ir_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_ir", i), ir, mem_word(tbl[i].e_pc));
      end else begin
        chk($sformatf("vec%0d_ir_nop", i), ir, NOP);
      end
    end
    chk_counts("tbl", n_ld, n_jmp);

    // Reset while a request is outstanding, then a stale ack in idle.
    pcjump = 1'b0; ir_bubble = 1'b0; id_ready = 1'b1;
    imem_if.imem_ack = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_req", {31'b0, imem_if.imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, ir_valid}, 32'd0);
    chk_counts("midrst", 0, 0);
    rst_n = 1'b1; imem_if.imem_ack = 1'b1;
    @(posedge clk); #1;
    $display("late ack: req=%0b addr=%h valid=%0b", imem_if.imem_req, imem_if.imem_addr, ir_valid);
    chk("lateack_req", {31'b0, imem_if.imem_req}, 32'd1);
    chk("lateack_addr", imem_if.imem_addr, RPC);
    chk("lateack_valid", {31'b0, ir_valid}, 32'd0);
    @(posedge clk); #1;
    chk("restart_valid", {31'b0, ir_valid}, 32'd1);
    chk("restart_pc", pc, RPC);
    chk("restart_ir", ir, mem_word(RPC));

    // Randomized traffic: the model tracks only the expected delivered pc stream.
    do_reset();
    exp_pc = RPC; last_pc = RPC; n_ld = 0; n_jmp = 0;
    for (int c = 0; c < 3000; c++) begin
      p_valid = ir_valid; p_req = imem_if.imem_req; p_addr = imem_if.imem_addr;
      pcjump    = ($urandom_range(0, 99) < 3);
      real_pc   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 255)) << 2);
      ir_bubble = ($urandom_range(0, 99) < 6);
      id_ready  = ($urandom_range(0, 99) < 70);
      imem_if.imem_ack = ($urandom_range(0, 99) < 60);
      p_jump = pcjump; p_tgt = real_pc; p_bub = ir_bubble; p_rdy = id_ready; p_ack = imem_if.imem_ack;
      @(posedge clk);
      #1;
      if (p_req && !p_ack) begin
        chk("rnd_req_hold", {31'b0, imem_if.imem_req}, 32'd1);
        chk("rnd_addr_hold", imem_if.imem_addr, p_addr);
      end
      if (p_jump) begin
        n_jmp++;
        exp_pc = p_tgt;
        chk("rnd_jump_valid", {31'b0, ir_valid}, 32'd0);
        chk("rnd_jump_ir", ir, NOP);
      end else if (p_bub) begin
        chk("rnd_bub_valid", {31'b0, ir_valid}, 32'd0);
        chk("rnd_bub_ir", ir, NOP);
      end else if (p_valid && !p_rdy) begin
        chk("rnd_hold_valid", {31'b0, ir_valid}, 32'd1);
        chk("rnd_hold_pc", pc, last_pc);
        chk("rnd_hold_ir", ir, mem_word(last_pc));
      end else if (ir_valid) begin
        chk("rnd_load_pc", pc, exp_pc);
        chk("rnd_load_ir", ir, mem_word(exp_pc));
        last_pc = exp_pc;
        exp_pc = exp_pc + 32'd4;
        n_ld++;
      end
    end
    $display("random: deliveries=%0d redirects=%0d", n_ld, n_jmp);
    chk("rnd_progress", {31'b0, (n_ld > 300)}, 32'd1);
    chk_counts("rnd", n_ld, n_jmp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
